// File: rtl/seq_run_detector_pkg.sv
// Shared encodings for the serial run detector: FSM states and z-path mode selectors.
package seq_det_pkg;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   localparam int MODE_MEALY = 0;
   localparam int MODE_MOORE = 1;

endpackage

// File: rtl/seq_run_detector_if.sv
// Sample/result bundle between the serial source and the run detector.
interface seq_run_detector_if #(
   parameter int RUN_LEN = 2,
   parameter int CNT_W   = 8
);
   localparam int RL_W = $clog2(RUN_LEN + 1);

   logic             en;
   logic             clr;
   logic             w;
   logic             z;
   logic             level;
   logic [RL_W-1:0]  run_cnt;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output en, clr, w,
      input  z, level, run_cnt, match_cnt
   );

   modport slave (
      input  en, clr, w,
      output z, level, run_cnt, match_cnt
   );

endinterface

// File: rtl/seq_run_detector_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment restarts the count at 1.
module sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v >= MAX) ? MAX : v + 1'b1;
   endfunction

   logic [W-1:0] base;

   assign base = clr ? '0 : count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (inc)
         count <= sat_inc(base);
      else if (clr)
         count <= '0;
   end

endmodule

// File: rtl/seq_run_detector.sv
// Run detector on serial stream w: flags every accepted bit that completes or extends
// a run of RUN_LEN identical bits, with Mealy or registered (Moore) z.
module seq_run_detector
   import seq_det_pkg::*;
#(
   parameter int RUN_LEN = 2,
   parameter int MOORE   = 0,
   parameter int CNT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   seq_run_detector_if.slave bus
);

   localparam int RL_W = $clog2(RUN_LEN + 1);

   state_t          state;
   state_t          state_nxt;
   logic            level;
   logic            hit;
   logic            run_inc;
   logic            run_rst;
   logic [RL_W-1:0] run_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= S_EMPTY;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.clr)
         state_nxt = S_EMPTY;
      else if (bus.en)
         state_nxt = S_RUN;
   end

   always_comb begin
      hit = 1'b0;
      if (bus.en && !bus.clr && (state == S_RUN) && (bus.w == level) &&
          (run_cnt >= RL_W'(RUN_LEN - 1)))
         hit = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         level <= 1'b0;
      else if (bus.clr)
         level <= 1'b0;
      else if (bus.en)
         level <= bus.w;
   end

   // A new run (first sample or a level change) clears and increments together, landing on 1.
   assign run_inc = bus.en & ~bus.clr;
   assign run_rst = bus.clr | (bus.en & ((state == S_EMPTY) | (bus.w != level)));

   sat_counter #(
      .W   (RL_W),
      .MAX (RL_W'(RUN_LEN))
   ) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (run_inc),
      .clr   (run_rst),
      .count (run_cnt)
   );

   sat_counter #(
      .W   (CNT_W),
      .MAX ({CNT_W{1'b1}})
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (hit),
      .clr   (bus.clr),
      .count (bus.match_cnt)
   );

   assign bus.level   = level;
   assign bus.run_cnt = run_cnt;

   generate
      if (MOORE == MODE_MOORE) begin : g_moore
         logic hit_p1;

         // hit is already forced low under clr, so loading it every cycle also clears z.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               hit_p1 <= 1'b0;
            else
               hit_p1 <= hit;
         end

         assign bus.z = hit_p1;
      end else begin : g_mealy
         assign bus.z = hit;
      end
   endgenerate

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed bench for seq_run_detector: stimulus pushes expected outputs, a negedge monitor checks them.
module tb_seq_run_detector;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic en = 1'b0;
   logic clr = 1'b0;
   logic w = 1'b0;

   always #5 clk = ~clk;

   seq_run_detector_if #(.RUN_LEN(2), .CNT_W(8)) i0 ();
   seq_run_detector_if #(.RUN_LEN(4), .CNT_W(8)) i1 ();
   seq_run_detector_if #(.RUN_LEN(3), .CNT_W(8)) i2 ();
   seq_run_detector_if #(.RUN_LEN(2), .CNT_W(2)) i3 ();
   seq_run_detector_if #(.RUN_LEN(4), .CNT_W(8)) i4 ();

   assign i0.en = en;  assign i0.clr = clr;  assign i0.w = w;
   assign i1.en = en;  assign i1.clr = clr;  assign i1.w = w;
   assign i2.en = en;  assign i2.clr = clr;  assign i2.w = w;
   assign i3.en = en;  assign i3.clr = clr;  assign i3.w = w;
   assign i4.en = en;  assign i4.clr = clr;  assign i4.w = w;

   seq_run_detector #(.RUN_LEN(2), .MOORE(0), .CNT_W(8)) d0 (.clk(clk), .reset(reset), .bus(i0));
   seq_run_detector #(.RUN_LEN(4), .MOORE(1), .CNT_W(8)) d1 (.clk(clk), .reset(reset), .bus(i1));
   seq_run_detector #(.RUN_LEN(3), .MOORE(0), .CNT_W(8)) d2 (.clk(clk), .reset(reset), .bus(i2));
   seq_run_detector #(.RUN_LEN(2), .MOORE(0), .CNT_W(2)) d3 (.clk(clk), .reset(reset), .bus(i3));
   seq_run_detector #(.RUN_LEN(4), .MOORE(0), .CNT_W(8)) d4 (.clk(clk), .reset(reset), .bus(i4));

   typedef struct {
      int    dut;
      string nm;
      bit    z;
      bit    lvl;
      int    rc;
      int    mc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   sel   = 0;

   // Scoreboard monitor: one expected observation per clock, taken at the falling edge.
   bit az, al;
   int arc, amc;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         case (e.dut)
            0: begin az = i0.z; al = i0.level; arc = int'(i0.run_cnt); amc = int'(i0.match_cnt); end
            1: begin az = i1.z; al = i1.level; arc = int'(i1.run_cnt); amc = int'(i1.match_cnt); end
            2: begin az = i2.z; al = i2.level; arc = int'(i2.run_cnt); amc = int'(i2.match_cnt); end
            3: begin az = i3.z; al = i3.level; arc = int'(i3.run_cnt); amc = int'(i3.match_cnt); end
            default: begin az = i4.z; al = i4.level; arc = int'(i4.run_cnt); amc = int'(i4.match_cnt); end
         endcase
         total++;
         if (az !== e.z) begin
            bad++;
            $display("FAIL %s z: got %0b want %0b", e.nm, az, e.z);
         end
         total++;
         if (al !== e.lvl) begin
            bad++;
            $display("FAIL %s level: got %0b want %0b", e.nm, al, e.lvl);
         end
         total++;
         if (arc != e.rc) begin
            bad++;
            $display("FAIL %s run_cnt: got %0d want %0d", e.nm, arc, e.rc);
         end
         total++;
         if (amc != e.mc) begin
            bad++;
            $display("FAIL %s match_cnt: got %0d want %0d", e.nm, amc, e.mc);
         end
      end
   end

   task automatic push(input string nm, input bit ez, input bit el, input int erc, input int emc);
      exp_t e;
      e.dut = sel; e.nm = nm; e.z = ez; e.lvl = el; e.rc = erc; e.mc = emc;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs just after the rising edge and queue what the falling edge must show.
   task automatic step(input string nm, input bit ven, input bit vclr, input bit vw,
                       input bit ez, input bit el, input int erc, input int emc);
      @(posedge clk);
      #1;
      en = ven; clr = vclr; w = vw;
      push(nm, ez, el, erc, emc);
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #1;
      reset = 1'b0; en = 1'b0; clr = 1'b0; w = 1'b0;
      push(nm, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);

      // RUN_LEN=2 Mealy: w=0,0,1,1,1,0
      sel = 0;
      do_reset("t1_rst");
      step("t1_s1", 1, 0, 0, 0, 0, 0, 0);
      step("t1_s2", 1, 0, 0, 1, 0, 1, 0);
      step("t1_s3", 1, 0, 1, 0, 0, 2, 1);
      step("t1_s4", 1, 0, 1, 1, 1, 1, 1);
      step("t1_s5", 1, 0, 1, 1, 1, 2, 2);
      step("t1_s6", 1, 0, 0, 0, 1, 2, 3);
      step("t1_end", 0, 0, 0, 0, 0, 1, 3);
      // clr with a matching bit, Mealy
      step("t6m_clr", 1, 1, 0, 0, 0, 1, 3);
      step("t6m_post", 0, 0, 0, 0, 0, 0, 0);

      // RUN_LEN=4 Moore: w=1,1,1,1,1,0,0,0,0
      sel = 1;
      do_reset("t2_rst");
      step("t2_s1", 1, 0, 1, 0, 0, 0, 0);
      step("t2_s2", 1, 0, 1, 0, 1, 1, 0);
      step("t2_s3", 1, 0, 1, 0, 1, 2, 0);
      step("t2_s4", 1, 0, 1, 0, 1, 3, 0);
      step("t2_s5", 1, 0, 1, 1, 1, 4, 1);
      step("t2_s6", 1, 0, 0, 1, 1, 4, 2);
      step("t2_s7", 1, 0, 0, 0, 0, 1, 2);
      step("t2_s8", 1, 0, 0, 0, 0, 2, 2);
      step("t2_s9", 1, 0, 0, 0, 0, 3, 2);
      step("t2_a1", 0, 0, 0, 1, 0, 4, 3);
      step("t2_a2", 0, 0, 0, 0, 0, 4, 3);
      // clr with a matching bit, Moore
      step("t6o_clr", 1, 1, 0, 0, 0, 4, 3);
      step("t6o_post", 0, 0, 0, 0, 0, 0, 0);

      // RUN_LEN=3 with an enable gap
      sel = 2;
      do_reset("t3_rst");
      step("t3_s1", 1, 0, 1, 0, 0, 0, 0);
      step("t3_s2", 1, 0, 1, 0, 1, 1, 0);
      step("t3_g1", 0, 0, 1, 0, 1, 2, 0);
      step("t3_g2", 0, 0, 1, 0, 1, 2, 0);
      step("t3_g3", 0, 0, 1, 0, 1, 2, 0);
      step("t3_s3", 1, 0, 1, 1, 1, 2, 0);
      step("t3_end", 0, 0, 1, 0, 1, 3, 1);

      // CNT_W=2 saturation then clear
      sel = 3;
      do_reset("t4_rst");
      step("t4_s1", 1, 0, 0, 0, 0, 0, 0);
      step("t4_s2", 1, 0, 0, 1, 0, 1, 0);
      for (int i = 3; i <= 10; i++) begin
         step($sformatf("t4_s%0d", i), 1, 0, 0, 1, 0, 2, (i - 2 > 3) ? 3 : i - 2);
      end
      step("t4_clr", 1, 1, 0, 0, 0, 2, 3);
      step("t4_after", 1, 0, 0, 0, 0, 0, 0);
      step("t4_end", 0, 0, 0, 0, 0, 1, 0);

      // Asynchronous reset mid-run, RUN_LEN=4 Mealy
      sel = 4;
      do_reset("t5_rst");
      step("t5_s1", 1, 0, 1, 0, 0, 0, 0);
      step("t5_s2", 1, 0, 1, 0, 1, 1, 0);
      step("t5_s3", 1, 0, 1, 0, 1, 2, 0);
      step("t5_hold", 0, 0, 1, 0, 1, 3, 0);
      @(posedge clk);
      #2;
      reset = 1'b0; en = 1'b1; w = 1'b1;
      push("t5_async", 0, 0, 0, 0);
      @(negedge clk);
      #1;
      en = 1'b0;
      reset = 1'b1;
      step("t5_first", 1, 0, 1, 0, 0, 0, 0);
      step("t5_end", 0, 0, 1, 0, 1, 1, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
